refresh_scan_gen: RTL
=====================

// Module: refresh_scan_gen
// PURPOSE
//  Parametrised refresh/scan timebase for multiplexed 7-segment displays. Divides
//  clk by a runtime-programmable divisor, emits a 1-cycle tick, a toggling refresh
//  square wave and a wrapping digit index with one-hot anode drive. Sits between
//  the board clock and the display mux; counters and the display datapath consume its outputs.
// PARAMETERS
//  CNT_W            16      width of divide counter and div_in
//  DIV_DEFAULT      50000   divisor after reset (50 MHz -> 1 kHz tick)
//  NUM_DIGITS       4       digits scanned (>=1); IDX_W = max(1, clog2(NUM_DIGITS))
//  ANODE_ACTIVE_LOW 1       1: selected anode driven 0, others 1; 0: inverse
//  BLANK_CYCLES     8       blanking length, used only with REFRESH_BLANK_EN
// PORTS
//  clk         in   1          system clock, all logic on rising edge
//  rst         in   1          synchronous reset, active-high
//  en          in   1          count enable; low freezes all state
//  div_wr      in   1          write strobe for new divisor
//  div_in      in   CNT_W      requested divisor (period in clk cycles)
//  div_pending out  1          accepted divisor not yet applied
//  tick        out  1          1-cycle pulse once per divisor period
//  refresh     out  1          toggles on every tick (50% square, period 2*div)
//  digit_idx   out  IDX_W      current digit, 0..NUM_DIGITS-1
//  anode       out  NUM_DIGITS one-hot digit select at ANODE_ACTIVE_LOW polarity
//  blank       out  1          1 while anodes forced inactive (0 if macro absent)
// BEHAVIOUR
//  - Reset (rst=1 at edge): cnt=0, div_active=DIV_DEFAULT, pend=0, div_pending=0,
//    tick=0, refresh=0, digit_idx=0, anode=bit0 active, blank=0. rst beats all inputs.
//  - All outputs registered. cnt runs 0..div_active-1 while en=1.
//  - Edge with en=1 and cnt==div_active-1: cnt<=0, tick<=1, refresh<=~refresh,
//    digit_idx<=(digit_idx==NUM_DIGITS-1)?0:digit_idx+1, anode follows new idx.
//    Any other edge: tick<=0. First tick high after exactly DIV_DEFAULT enabled edges.
//  - en=0: cnt, refresh, digit_idx, anode hold; tick<=0. Resume continues count.
//  - Divisor load: div_wr=1 latches pend<=clamp(div_in), div_pending<=1 (any en).
//    Applied only at a terminal-count edge: div_active<=pend, div_pending<=0; the
//    period in progress always completes with old value (no short/long glitch period).
//    div_wr in same cycle as terminal count: value goes to pend, applied at the
//    FOLLOWING terminal count. Second div_wr while pending overwrites pend.
//  - clamp: div_in<2 -> 2 (no macro); div_in<BLANK_CYCLES+2 -> BLANK_CYCLES+2 (macro).
//  - NUM_DIGITS=1: digit_idx stays 0, anode constant, refresh/tick still run.
//  - div_in max 2^CNT_W-1; no wider arithmetic; cnt compare is equality only.
// CONFIGURATION
//  REFRESH_BLANK_EN defined: on each tick edge blank<=1 and all anodes inactive for
//    BLANK_CYCLES cycles (counted on en=1 edges), then blank<=0 and new anode
//    active. en=0 freezes the blank counter. rst clears blank.
//  Not defined: blank tied 0, anode changes on the tick edge, BLANK_CYCLES ignored.
// TESTING (DIV_DEFAULT=10, NUM_DIGITS=4, ANODE_ACTIVE_LOW=1 unless stated)
//  1 rst then en=1 -> tick on edge 10,20,30..; refresh 0->1->0; anode 1110,1101,1011,0111,1110.
//  2 en low 5 cycles mid-period (cnt=4) -> no tick; next tick 15 edges after first, idx unchanged while low.
//  3 div_wr div_in=4 at cnt=3 -> div_pending=1; current period stays 10, then ticks every 4.
//  4 div_wr=4 on terminal-count cycle -> one more period of 10, then 4; div_in=0 -> period 2.
//  5 rst asserted at cnt=7, idx=2 -> next edge all reset values; div_active back to 10.
//  6 REFRESH_BLANK_EN, BLANK_CYCLES=3 -> after each tick anode=1111, blank=1 for 3 cycles,
//    then next digit active; div_in=2 clamps to 5.

Source files
------------

// File: rtl/refresh_scan_gen.sv
// -----------------------------------------------------------------------------
// refresh_scan_gen
//
// Refresh/scan timebase for a multiplexed 7-segment display. The block divides
// clk_i by a divisor that can be changed at runtime. Each completed divisor
// period produces:
//   - a one-cycle tick,
//   - a toggle of the refresh square wave,
//   - an advance of the wrapping digit index,
//   - a matching one-hot anode select.
//
// Optional feature (compile-time macro REFRESH_BLANK_EN):
//   When defined, every tick starts a blanking window of BLANK_CYCLES enabled
//   cycles. During the window all anodes are inactive and blank_o is high.
//   The new digit's anode turns on when the window ends. When the macro is not
//   defined, blank_o is tied low and the anode changes on the tick edge.
//
// Ports
//   clk_i          system clock; all logic runs on the rising edge
//   rst_i          synchronous reset, active high; overrides every other input
//   en_i           count enable; when low, all state holds and tick_o drops
//   div_wr_i       write strobe for a new divisor
//   div_in_i       requested divisor (period in clk_i cycles); small values
//                  are clamped up to a minimum
//   div_pending_o  a divisor has been accepted but not yet applied
//   tick_o         one-cycle pulse once per divisor period
//   refresh_o      toggles on every tick (50% duty, period 2*divisor)
//   digit_idx_o    current digit, 0..NUM_DIGITS-1
//   anode_o        one-hot digit select, polarity set by ANODE_ACTIVE_LOW
//   blank_o        high while the anodes are forced inactive
// -----------------------------------------------------------------------------
module refresh_scan_gen #(
    parameter int CNT_W            = 16,
    parameter int DIV_DEFAULT      = 50000,
    parameter int NUM_DIGITS       = 4,
    parameter int ANODE_ACTIVE_LOW = 1,
    parameter int BLANK_CYCLES     = 8,
    localparam int IDX_W           = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  div_wr_i,
    input  logic [CNT_W-1:0]      div_in_i,
    output logic                  div_pending_o,
    output logic                  tick_o,
    output logic                  refresh_o,
    output logic [IDX_W-1:0]      digit_idx_o,
    output logic [NUM_DIGITS-1:0] anode_o,
    output logic                  blank_o
);

    // Reject parameter sets the datapath cannot honour.
    if (NUM_DIGITS < 1 || DIV_DEFAULT < 2 || BLANK_CYCLES < 1) begin : g_param_check
        $error("refresh_scan_gen: NUM_DIGITS>=1, DIV_DEFAULT>=2, BLANK_CYCLES>=1 required");
    end

`ifdef REFRESH_BLANK_EN
    // The divisor floor keeps the blanking window shorter than one period, so
    // the window always ends before the next tick.
    localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(BLANK_CYCLES + 2);
    localparam int               BLK_W   = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BLK_W-1:0] BLK_LOAD = BLK_W'(BLANK_CYCLES - 1);
`else
    localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);
`endif

    localparam logic [CNT_W-1:0]      DIV_RST   = CNT_W'(DIV_DEFAULT);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW != 0}};

    // Anode pattern that selects digit idx at the configured polarity.
    function automatic logic [NUM_DIGITS-1:0] anode_of(input logic [IDX_W-1:0] idx);
        logic [NUM_DIGITS-1:0] sel;
        sel = NUM_DIGITS'(1) << idx;
        return (ANODE_ACTIVE_LOW != 0) ? ~sel : sel;
    endfunction

    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

    // State registers and their next-state values.
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      div_active_q, div_active_d;
    logic [CNT_W-1:0]      pend_q, pend_d;
    logic                  pending_q, pending_d;
    logic                  tick_q, tick_d;
    logic                  refresh_q, refresh_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
`ifdef REFRESH_BLANK_EN
    logic                  blank_q, blank_d;
    logic [BLK_W-1:0]      blank_cnt_q, blank_cnt_d;
`endif

    logic             terminal;
    logic [IDX_W-1:0] idx_next;

    // Equality compare only. div_active_q is never below 2, so subtracting
    // one cannot wrap.
    assign terminal = (cnt_q == div_active_q - CNT_W'(1));
    assign idx_next = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);

    always_comb begin
        // NOTE: every signal driven here gets a default first. Without it,
        // a path that skips an assignment would infer a latch.
        cnt_d        = cnt_q;
        div_active_d = div_active_q;
        pend_d       = pend_q;
        pending_d    = pending_q;
        tick_d       = 1'b0;
        refresh_d    = refresh_q;
        idx_d        = idx_q;
        anode_d      = anode_q;
`ifdef REFRESH_BLANK_EN
        blank_d      = blank_q;
        blank_cnt_d  = blank_cnt_q;
`endif

        if (en_i) begin
            if (terminal) begin
                cnt_d     = '0;
                tick_d    = 1'b1;
                refresh_d = ~refresh_q;
                idx_d     = idx_next;
                // A pending divisor is applied only here, so the period in
                // progress always finishes with the old value.
                if (pending_q) begin
                    div_active_d = pend_q;
                    pending_d    = 1'b0;
                end
`ifdef REFRESH_BLANK_EN
                blank_d     = 1'b1;
                blank_cnt_d = BLK_LOAD;
                anode_d     = ANODE_OFF;
`else
                anode_d     = anode_of(idx_next);
`endif
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
`ifdef REFRESH_BLANK_EN
                if (blank_q) begin
                    if (blank_cnt_q == '0) begin
                        blank_d = 1'b0;
                        anode_d = anode_of(idx_q);
                    end else begin
                        blank_cnt_d = blank_cnt_q - BLK_W'(1);
                    end
                end
`endif
            end
        end

        // A write on a terminal-count edge lands in pend_q and waits for the
        // following terminal count. It also overrides the pending-clear above.
        if (div_wr_i) begin
            pend_d    = clamp_div(div_in_i);
            pending_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the values from before the edge regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q        <= '0;
            div_active_q <= DIV_RST;
            pend_q       <= DIV_RST;
            pending_q    <= 1'b0;
            tick_q       <= 1'b0;
            refresh_q    <= 1'b0;
            idx_q        <= '0;
            anode_q      <= anode_of('0);
`ifdef REFRESH_BLANK_EN
            blank_q      <= 1'b0;
            blank_cnt_q  <= '0;
`endif
        end else begin
            cnt_q        <= cnt_d;
            div_active_q <= div_active_d;
            pend_q       <= pend_d;
            pending_q    <= pending_d;
            tick_q       <= tick_d;
            refresh_q    <= refresh_d;
            idx_q        <= idx_d;
            anode_q      <= anode_d;
`ifdef REFRESH_BLANK_EN
            blank_q      <= blank_d;
            blank_cnt_q  <= blank_cnt_d;
`endif
        end
    end

    assign div_pending_o = pending_q;
    assign tick_o        = tick_q;
    assign refresh_o     = refresh_q;
    assign digit_idx_o   = idx_q;
    assign anode_o       = anode_q;
`ifdef REFRESH_BLANK_EN
    assign blank_o       = blank_q;
`else
    assign blank_o       = 1'b0;
`endif

endmodule
